// File: rtl/muldiv_hilo_unit_if.sv
// Request/response bundle between the instruction controller and the HI/LO multiply/divide unit.
// The slave side is the arithmetic unit; the master side drives the operation requests.
interface muldiv_hilo_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [3:0]       i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_lo_or_hi;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;
   logic [WIDTH-1:0] o_mf_data;

   modport slave (
      input  i_start, i_op, i_a, i_b, i_lo_or_hi,
      output o_busy, o_done, o_hi, o_lo, o_mf_data
   );

   modport master (
      output i_start, i_op, i_a, i_b, i_lo_or_hi,
      input  o_busy, o_done, o_hi, o_lo, o_mf_data
   );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle signed multiply/divide unit owning HI/LO: magnitude shift-add / restoring
// division over WIDTH cycles, then a single sign-fix cycle that writes HI/LO.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   muldiv_hilo_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [3:0]       OP_MULT  = 4'b0001;
   localparam logic [3:0]       OP_DIV   = 4'b0011;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_absA;
   logic [WIDTH-1:0]   r_absB;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_prod;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_signA;
   logic               r_signB;
   logic               r_isDiv;
   logic               r_busy;
   logic               r_done;

   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic               w_opValid;
   logic [WIDTH:0]     w_multSum;
   logic [WIDTH:0]     w_divShift;
   logic               w_divGe;
   logic [WIDTH-1:0]   w_divDiff;
   logic [2*WIDTH-1:0] w_prodFix;
   logic [WIDTH-1:0]   w_quoFix;
   logic [WIDTH-1:0]   w_remFix;

   // The most-negative operand has a magnitude that still fits as an unsigned WIDTH-bit value.
   assign w_absA    = bus.i_a[WIDTH-1] ? (-bus.i_a) : bus.i_a;
   assign w_absB    = bus.i_b[WIDTH-1] ? (-bus.i_b) : bus.i_b;
   assign w_opValid = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);

   assign w_multSum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_absA : '0)};
   assign w_divShift = {r_rem, r_quo[WIDTH-1]};
   assign w_divGe    = w_divShift >= {1'b0, r_absB};
   assign w_divDiff  = w_divShift[WIDTH-1:0] - r_absB;

   // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
   assign w_prodFix = (r_signA ^ r_signB) ? (-r_prod) : r_prod;
   assign w_quoFix  = ((r_signA ^ r_signB) && (r_absB != '0)) ? (-r_quo) : r_quo;
   assign w_remFix  = r_signA ? (-r_rem) : r_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_absA  <= '0;
         r_absB  <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
         r_signA <= 1'b0;
         r_signB <= 1'b0;
         r_isDiv <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.i_start && w_opValid) begin
                  r_absA  <= w_absA;
                  r_absB  <= w_absB;
                  r_signA <= bus.i_a[WIDTH-1];
                  r_signB <= bus.i_b[WIDTH-1];
                  r_isDiv <= (bus.i_op == OP_DIV);
                  r_prod  <= {{WIDTH{1'b0}}, w_absB};
                  r_quo   <= w_absA;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               // Multiplier bits leave r_prod from the bottom as the partial product enters the top.
               if (r_isDiv) begin
                  r_rem <= w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], w_divGe};
               end else begin
                  r_prod <= {w_multSum, r_prod[WIDTH-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               if (r_isDiv) begin
                  r_hi <= w_remFix;
                  r_lo <= w_quoFix;
               end else begin
                  r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prodFix[WIDTH-1:0];
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_busy    = r_busy;
   assign bus.o_done    = r_done;
   assign bus.o_hi      = r_hi;
   assign bus.o_lo      = r_lo;
   assign bus.o_mf_data = bus.i_lo_or_hi ? r_hi : r_lo;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed corner cases plus randomized operations
// compared against a signed-arithmetic reference model of HI/LO.
module tb_muldiv_hilo_unit;
   localparam int WIDTH = 32;
   localparam logic [3:0] OP_MULT = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b0011;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] expHi = '0;
   logic [31:0] expLo = '0;

   always #5 clk = ~clk;

   muldiv_hilo_unit_if #(.WIDTH(WIDTH)) bus ();

   muldiv_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Signed 64-bit product for mult; truncating signed quotient/remainder for div.
   function automatic logic [63:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int     q;
      int     r;
      if (op == OP_MULT) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return p;
      end
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   task automatic checkHiLo(input string tag);
      checkOutput({tag, "_hilo"}, {bus.o_hi, bus.o_lo}, {expHi, expLo});
      bus.i_lo_or_hi = 1'b0;
      #1 checkOutput({tag, "_mf_lo"}, bus.o_mf_data, expLo);
      bus.i_lo_or_hi = 1'b1;
      #1 checkOutput({tag, "_mf_hi"}, bus.o_mf_data, expHi);
      bus.i_lo_or_hi = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int injectAt);
      logic [63:0] res;
      int k = 0;
      int busyCycles = 0;
      bit seen = 1'b0;
      res = refModel(op, a, b);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_a     = $urandom;
      bus.i_b     = $urandom;
      while (k < 60 && !seen) begin
         if (bus.o_done) begin
            seen = 1'b1;
         end else begin
            if (bus.o_busy) busyCycles++;
            if (k == 5) begin
               checkOutput("hold_hilo", {bus.o_hi, bus.o_lo}, {expHi, expLo});
               checkOutput("hold_mf", bus.o_mf_data, expLo);
            end
            if (k == injectAt) begin
               bus.i_start = 1'b1;
               bus.i_op    = OP_MULT;
               bus.i_a     = 32'd9;
               bus.i_b     = 32'd9;
            end else begin
               bus.i_start = 1'b0;
            end
            @(negedge clk);
            k++;
         end
      end
      bus.i_start = 1'b0;
      checkOutput("done_seen", 64'(seen), 64'd1);
      checkOutput("latency", 64'(k), 64'(WIDTH + 1));
      checkOutput("busy_cycles", 64'(busyCycles), 64'(WIDTH + 1));
      checkOutput("busy_at_done", 64'(bus.o_busy), 64'd0);
      expHi = res[63:32];
      expLo = res[31:0];
      checkHiLo("result");
      @(negedge clk);
      checkOutput("done_pulse", 64'(bus.o_done), 64'd0);
      checkOutput("busy_idle", 64'(bus.o_busy), 64'd0);
   endtask

   task automatic abortWithReset(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int resetAt);
      int doneCount = 0;
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (resetAt) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expHi = '0;
      expLo = '0;
      checkOutput("abort_busy", 64'(bus.o_busy), 64'd0);
      checkOutput("abort_done", 64'(bus.o_done), 64'd0);
      checkHiLo("abort");
      repeat (40) begin
         @(negedge clk);
         if (bus.o_done) doneCount++;
      end
      checkOutput("abort_no_done", 64'(doneCount), 64'd0);
   endtask

   task automatic illegalStart(input logic [3:0] op);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = $urandom;
      bus.i_b     = $urandom;
      @(negedge clk);
      bus.i_start = 1'b0;
      checkOutput("illegal_busy0", 64'(bus.o_busy), 64'd0);
      @(negedge clk);
      checkOutput("illegal_busy1", 64'(bus.o_busy), 64'd0);
      checkOutput("illegal_done", 64'(bus.o_done), 64'd0);
      checkOutput("illegal_hilo", {bus.o_hi, bus.o_lo}, {expHi, expLo});
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      rst            = 1'b1;
      bus.i_start    = 1'b0;
      bus.i_op       = '0;
      bus.i_a        = '0;
      bus.i_b        = '0;
      bus.i_lo_or_hi = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
      checkOutput("reset_done", 64'(bus.o_done), 64'd0);
      checkHiLo("reset");
      rst = 1'b0;

      applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFD, -1);
      applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1);
      applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      applyStimulus(OP_DIV, 32'd17, -32'sd5, -1);
      applyStimulus(OP_DIV, -32'sd17, 32'd5, -1);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      applyStimulus(OP_DIV, 32'h0000_1234, 32'h0, -1);
      applyStimulus(OP_MULT, 32'd6, 32'd7, -1);
      applyStimulus(OP_DIV, 32'd100, 32'd7, 5);
      illegalStart(4'b0010);
      applyStimulus(OP_MULT, 32'd3, 32'd4, -1);
      abortWithReset(OP_DIV, 32'd50, 32'd5, 10);
      applyStimulus(OP_MULT, 32'd2, 32'd3, -1);

      for (int i = 0; i < 16; i++) begin
         op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: b = $urandom_range(0, 3);
            2: b = -32'($urandom_range(1, 20));
            default: ;
         endcase
         applyStimulus(op, a, b, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
